// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC register and next-PC selector. If a branch or jump resolves
// while fetch is stalled, its target is buffered so the redirect is not lost.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flush_exc,
    input  logic [31:0] exc_pc,
    input  logic        branchD,
    input  logic        jumpD,
    input  logic        jrD,
    input  logic        taken,
    input  logic [31:0] pc_plus4D,
    input  logic [31:0] imm_extD,
    input  logic [25:0] instr_indexD,
    input  logic [31:0] rs_dataD,
    output logic [31:0] pcF,
    output logic [31:0] pc_plus4F,
    output logic        in_delayslotD,
    output logic        adelF,
    output logic        pend_valid
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_valid_q, pend_valid_d;
    logic        delayslot_q, delayslot_d;
    logic [31:0] target_s;
    logic        redirect_s;
    logic        is_cti_s;

    // JR wins over J, and J wins over a conditional branch, if decode sets several bits
    function automatic logic [31:0] calc_target(
        input logic        jr,
        input logic        jump,
        input logic [31:0] pc_plus4,
        input logic [31:0] imm_ext,
        input logic [25:0] instr_index,
        input logic [31:0] rs_data
    );
        logic [31:0] result;
        if (jr) begin
            result = rs_data;
        end else if (jump) begin
            result = {pc_plus4[31:28], instr_index, 2'b00};
        end else begin
            result = pc_plus4 + {imm_ext[29:0], 2'b00};
        end
        return result;
    endfunction

    // Target and redirect qualification
    always_comb begin
        target_s   = calc_target(jrD, jumpD, pc_plus4D, imm_extD, instr_indexD, rs_dataD);
        is_cti_s   = branchD | jumpD | jrD;
        redirect_s = ~stallD & ((branchD & taken) | jumpD | jrD);
    end

    // Next-state selection: exception, then buffered redirect, then live redirect, then sequential
    always_comb begin
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;
        delayslot_d   = delayslot_q;
        if (flush_exc) begin
            pc_d         = exc_pc;
            pend_valid_d = 1'b0;
            delayslot_d  = 1'b0;
        end else begin
            if (stallF) begin
                // Only the first redirect seen during a stall is kept
                if (redirect_s && !pend_valid_q) begin
                    pend_target_d = target_s;
                    pend_valid_d  = 1'b1;
                end else begin
                    pend_valid_d  = pend_valid_q;
                end
            end else if (pend_valid_q) begin
                pc_d         = pend_target_q;
                pend_valid_d = 1'b0;
            end else if (redirect_s) begin
                pc_d = target_s;
            end else begin
                pc_d = pc_q + 32'd4;
            end
            if (!stallD) begin
                delayslot_d = is_cti_s;
            end else begin
                delayslot_d = delayslot_q;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            pend_target_q <= 32'h0000_0000;
            pend_valid_q  <= 1'b0;
            delayslot_q   <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
            delayslot_q   <= delayslot_d;
        end
    end

    // Outputs derived from registered state only
    always_comb begin
        pcF           = pc_q;
        pc_plus4F     = pc_q + 32'd4;
        adelF         = (pc_q[1:0] != 2'b00);
        pend_valid    = pend_valid_q;
        in_delayslotD = delayslot_q;
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: directed scenarios then random traffic.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst, stallF, stallD, flush_exc, branchD, jumpD, jrD, taken;
    logic [31:0] exc_pc, pc_plus4D, imm_extD, rs_dataD;
    logic [25:0] instr_indexD;
    logic [31:0] pcF, pc_plus4F;
    logic        in_delayslotD, adelF, pend_valid;

    always #5 clk = ~clk;

    pc_redirect_unit dut (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD),
        .flush_exc(flush_exc), .exc_pc(exc_pc), .branchD(branchD),
        .jumpD(jumpD), .jrD(jrD), .taken(taken), .pc_plus4D(pc_plus4D),
        .imm_extD(imm_extD), .instr_indexD(instr_indexD), .rs_dataD(rs_dataD),
        .pcF(pcF), .pc_plus4F(pc_plus4F), .in_delayslotD(in_delayslotD),
        .adelF(adelF), .pend_valid(pend_valid)
    );

    typedef struct {
        bit          rst, sF, sD, fe, b, j, jr, t;
        logic [31:0] epc, p4, imm, rs;
        logic [25:0] idx;
    } stim_t;

    typedef struct {
        logic [31:0] pc, pc4;
        logic        ds, adel, pv;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state, architectural view
    logic [31:0] m_pc, m_pt;
    logic        m_pv, m_ds;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Applies one cycle of stimulus, predicts the post-edge state, pushes it.
    task automatic drive(input stim_t s);
        logic [31:0] tgt;
        bit          redir;
        exp_t        e;
        rst = s.rst; stallF = s.sF; stallD = s.sD; flush_exc = s.fe;
        exc_pc = s.epc; branchD = s.b; jumpD = s.j; jrD = s.jr; taken = s.t;
        pc_plus4D = s.p4; imm_extD = s.imm; instr_indexD = s.idx; rs_dataD = s.rs;

        if (s.jr)     tgt = s.rs;
        else if (s.j) tgt = {s.p4[31:28], s.idx, 2'b00};
        else          tgt = s.p4 + (s.imm << 2);
        redir = !s.sD && ((s.b && s.t) || s.j || s.jr);

        if (s.rst) begin
            m_pc = 32'hBFC0_0000; m_pv = 1'b0; m_pt = 32'h0; m_ds = 1'b0;
        end else if (s.fe) begin
            m_pc = s.epc; m_pv = 1'b0; m_ds = 1'b0;
        end else begin
            if (s.sF) begin
                if (redir && !m_pv) begin m_pt = tgt; m_pv = 1'b1; end
            end else if (m_pv) begin
                m_pc = m_pt; m_pv = 1'b0;
            end else if (redir) begin
                m_pc = tgt;
            end else begin
                m_pc = m_pc + 32'd4;
            end
            if (!s.sD) m_ds = s.b | s.j | s.jr;
        end
        e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.ds = m_ds;
        e.adel = (m_pc % 4) != 0; e.pv = m_pv;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compares DUT state just after each active edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pcF", pcF, e.pc);
            chk("pc_plus4F", pc_plus4F, e.pc4);
            chk("in_delayslotD", {31'd0, in_delayslotD}, {31'd0, e.ds});
            chk("adelF", {31'd0, adelF}, {31'd0, e.adel});
            chk("pend_valid", {31'd0, pend_valid}, {31'd0, e.pv});
        end
    end

    initial begin
        stim_t s;
        // Reset and sequential fetch
        s = idle(); s.rst = 1'b1; drive(s);
        chk("reset_pc", pcF, 32'hBFC0_0000);
        chk("reset_pend", {31'd0, pend_valid}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            drive(idle());
            chk("seq_pc", pcF, 32'hBFC0_0000 + 32'(4 * i));
        end
        chk("seq_adel", {31'd0, adelF}, 32'd0);

        // Taken and not-taken branch
        s = idle(); s.b = 1'b1; s.t = 1'b1; s.p4 = 32'hBFC0_0008; s.imm = 32'hFFFF_FFFE;
        drive(s);
        chk("br_taken_pc", pcF, 32'hBFC0_0000);
        chk("br_taken_ds", {31'd0, in_delayslotD}, 32'd1);
        s.t = 1'b0; drive(s);
        chk("br_nt_pc", pcF, 32'hBFC0_0004);
        chk("br_nt_ds", {31'd0, in_delayslotD}, 32'd1);

        // J then JR to a misaligned address
        s = idle(); s.j = 1'b1; s.p4 = 32'h9000_0010; s.idx = 26'h000_0100; drive(s);
        chk("j_pc", pcF, 32'h9000_0400);
        s = idle(); s.jr = 1'b1; s.rs = 32'h0000_1002; drive(s);
        chk("jr_pc", pcF, 32'h0000_1002);
        chk("jr_adel", {31'd0, adelF}, 32'd1);

        // Redirect buffered across a 3-cycle fetch stall
        s = idle(); s.sF = 1'b1; s.b = 1'b1; s.t = 1'b1; s.p4 = 32'hBFC0_00F0; s.imm = 32'h4;
        drive(s);
        chk("stall_pend", {31'd0, pend_valid}, 32'd1);
        chk("stall_hold", pcF, 32'h0000_1002);
        s = idle(); s.sF = 1'b1; s.jr = 1'b1; s.rs = 32'h1111_1110; drive(s);
        s = idle(); s.sF = 1'b1; drive(s);
        chk("stall_hold2", pcF, 32'h0000_1002);
        drive(idle());
        chk("release_pc", pcF, 32'hBFC0_0100);
        chk("release_pend", {31'd0, pend_valid}, 32'd0);

        // Exception during stall with pending redirect
        s = idle(); s.sF = 1'b1; s.jr = 1'b1; s.rs = 32'h1234_5678; drive(s);
        s = idle(); s.sF = 1'b1; s.fe = 1'b1; s.epc = 32'hBFC0_0380; s.jr = 1'b1; s.rs = 32'h4;
        drive(s);
        chk("exc_pc", pcF, 32'hBFC0_0380);
        chk("exc_pend", {31'd0, pend_valid}, 32'd0);
        chk("exc_ds", {31'd0, in_delayslotD}, 32'd0);

        // Reset mid-stall with pending and live redirect
        s = idle(); s.sF = 1'b1; s.jr = 1'b1; s.rs = 32'h0000_2000; drive(s);
        s.rst = 1'b1; drive(s);
        chk("rst_mid_pc", pcF, 32'hBFC0_0000);
        chk("rst_mid_pend", {31'd0, pend_valid}, 32'd0);
        chk("rst_mid_ds", {31'd0, in_delayslotD}, 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            s.rst = ($urandom_range(99) < 2);
            s.sF  = ($urandom_range(99) < 35);
            s.sD  = ($urandom_range(99) < 25);
            s.fe  = ($urandom_range(99) < 5);
            s.b   = ($urandom_range(99) < 30);
            s.j   = ($urandom_range(99) < 15);
            s.jr  = ($urandom_range(99) < 15);
            s.t   = $urandom_range(1);
            s.epc = $urandom;
            s.p4  = $urandom;
            s.imm = ($urandom_range(1) == 1) ? 32'($signed($urandom_range(65535) - 32768)) : $urandom;
            s.rs  = $urandom;
            s.idx = 26'($urandom);
            drive(s);
        end
        @(posedge clk); #2;
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
